// File: rtl/router_in_arb.sv
// router_in_arb: packet-level round-robin arbiter sharing one router input
// port among three sources; the grant is held from header through parity.
module router_in_arb #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [2:0]          src_req,
  input  logic [2:0]          src_valid,
  input  logic [3*DATA_W-1:0] src_data,
  input  logic                busy,
  output logic [2:0]          gnt,
  output logic [2:0]          src_busy,
  output logic                pkt_valid,
  output logic [DATA_W-1:0]   data_in,
  output logic                timeout_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HDR,
    PKT,
    DONE
  } state_e;

  state_e        state_q;
  logic [2:0]    gnt_q;
  logic [1:0]    ptr_q;
  logic [CW-1:0] cnt_q;
  logic          terr_q;

  logic [1:0] o1;
  logic [1:0] o2;
  logic [1:0] sel;
  logic       active;
  logic       gvalid;
  logic       greq;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Search order starts just past the last winner.
  assign o1 = nxt(ptr_q);
  assign o2 = nxt(o1);

  always_comb begin
    sel = ptr_q;
    if (src_req[o1])      sel = o1;
    else if (src_req[o2]) sel = o2;
  end

  assign active = (state_q == WAIT_HDR) || (state_q == PKT);
  assign gvalid = |(gnt_q & src_valid);
  assign greq   = |(gnt_q & src_req);

  always_comb begin
    data_in = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_q[i]) data_in = src_data[i*DATA_W +: DATA_W];
    end
  end

  assign pkt_valid   = active & gvalid;
  assign src_busy    = active ? ((gnt_q & {3{busy}}) | ~gnt_q)
                              : 3'b111;
  assign gnt         = gnt_q;
  assign timeout_err = terr_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= 2'd2;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      terr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|src_req) begin
            gnt_q   <= 3'b001 << sel;
            ptr_q   <= sel;
            cnt_q   <= '0;
            state_q <= WAIT_HDR;
          end
        end
        WAIT_HDR: begin
          if (gvalid && !busy) begin
            state_q <= PKT;
          end else if (!greq) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end else if (!gvalid) begin
            // Only cycles with valid low count toward revocation.
            if (cnt_q == TMAX) begin
              gnt_q   <= '0;
              terr_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        PKT: begin
          if (!busy && !gvalid) state_q <= DONE;
        end
        DONE: begin
          if (!busy) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/router_in_arb.md
# router_in_arb

Packet-level round-robin arbiter that shares the single router input port (`pkt_valid`, `data_in`, `busy`) among three upstream sources. It grants one source per packet and steers that source's valid and data to the router. It holds the grant from header through parity byte until the router FSM drops `busy`. It sits directly in front of the router's FSM, register and synchronizer blocks.

## Interface
- `DATA_W`, default 8: byte width of the packet stream.
- `TIMEOUT`, default 16: number of cycles a granted source may leave its valid low before the grant is revoked. Legal values ≥ 2.

Ports:
- `clock`, input, 1: rising-edge clock.
- `resetn`, input, 1: reset, synchronous, active-low.
- `src_req`, input, 3: per-source packet request. Held high until granted.
- `src_valid`, input, 3: per-source pkt_valid. High for the header and payload bytes, low on the parity byte.
- `src_data`, input, 3*DATA_W: per-source byte. Source i occupies bits [i*DATA_W +: DATA_W].
- `busy`, input, 1: router FSM busy.
- `gnt`, output, 3: one-hot registered grant.
- `src_busy`, output, 3: per-source stall.
- `pkt_valid`, output, 1: to router.
- `data_in`, output, DATA_W: to router.
- `timeout_err`, output, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, WAIT_HDR, PKT, DONE. Reset values:
  - state = IDLE
  - `gnt` = 000
  - `timeout_err` = 0
  - `ptr` = 2, so source 0 has first priority
  - timeout counter = 0
- IDLE:
  - If `src_req` ≠ 0, select the first requester in order ptr+1, ptr+2, ptr (mod 3).
  - On that edge: set `gnt` one-hot, set `ptr` = selected index, clear the counter, go to WAIT_HDR.
  - If `src_req` = 0, stay in IDLE.
- WAIT_HDR (granted index g):
  - If `src_valid[g]`=1 and `busy`=0: the header is accepted this cycle. Go to PKT.
  - Else if `src_req[g]`=0: clear `gnt` and go to IDLE, with no error.
  - Else if counter = TIMEOUT-1: clear `gnt`, go to IDLE, pulse `timeout_err`.
  - Else increment the counter.
- PKT:
  - When `busy`=0 and `src_valid[g]`=1: a payload byte is accepted; stay in PKT.
  - When `busy`=0 and `src_valid[g]`=0: the parity byte is accepted this cycle. Go to DONE.
  - When `busy`=1: hold state. The source is stalled.
- DONE:
  - `pkt_valid` is forced to 0.
  - When `busy`=0: clear `gnt` and go to IDLE.
  - Otherwise stay in DONE; this covers LOAD_PARITY, CHECK_PARITY_ERROR and FIFO-full.
- Combinational outputs:
  - `pkt_valid` = `src_valid[g]` when state ∈ {WAIT_HDR, PKT}; else 0.
  - `data_in` = `src_data[g]` when `gnt` ≠ 0; else 0.
  - `src_busy[i]` = `busy` when `gnt[i]`=1 and state ∈ {WAIT_HDR, PKT}; else 1.
- Source contract: a source holds `src_valid` and `src_data` stable while its `src_busy`=1.
- `src_req` is sampled only in IDLE and WAIT_HDR. Deasserting it during PKT or DONE has no effect.
- In WAIT_HDR the counter holds while `busy`=1 and `src_valid[g]`=1. It counts only cycles with `src_valid[g]`=0.
- Reset mid-packet (`resetn`=0 in any state): all state returns to reset values on the next edge. The router is reset by the same signal.

## Timing
- Grant latency: `gnt` is asserted 1 cycle after a request is sampled in IDLE.
- Release: `gnt` drops on the edge following the first DONE cycle with `busy`=0.
- Minimum gap from release to the next grant is 1 IDLE cycle. Back-to-back packets from different sources are therefore separated by at least 1 cycle with `gnt`=000.
- Timeout: `timeout_err` is high for exactly one cycle, coincident with the first IDLE cycle after revocation. This occurs TIMEOUT cycles after entry to WAIT_HDR when valid stays low.
- If the parity byte is accepted, DONE is entered on that edge. The router raises `busy` the following cycle, so the first DONE cycle normally sees `busy`=1.
- If a source's request coincides with its own release, it waits for the next IDLE arbitration. Rotation has already moved priority past it.

## Test plan
- Single source 1 sends header 0x0E (addr 2, len 3), payload 0x11/0x22/0x33, then parity:
  - `gnt` = 010 one cycle after `src_req[1]`.
  - `pkt_valid` and `data_in` mirror source 1.
  - `gnt` clears after the router `busy` falls.
  - `ptr` = 1.
- All three `src_req`=1 continuously from reset, each sending a 1-byte packet: grant order 001, 010, 100, 001, with ≥1 IDLE cycle between grants.
- Router `busy` held high 5 cycles mid-payload:
  - `src_busy[g]`=1 for 5 cycles; the state stays PKT.
  - `data_in` is held.
  - Other sources see `src_busy`=1 throughout.
- Source 0 granted, never raises valid, TIMEOUT=16:
  - `timeout_err` pulses exactly once, 16 cycles after `gnt`=001.
  - `gnt` = 000, and the next grant goes to source 1 if it is requesting.
- FIFO full after parity (router `busy` stays high 10 cycles in DONE): `gnt` held for those 10 cycles, `pkt_valid`=0 throughout.
- `resetn`=0 asserted during PKT: next cycle `gnt`=000, `pkt_valid`=0, `src_busy`=111, and source 0 has priority on the next request.
